// File: rtl/axil_regfile_ctrl_if.sv
// AXI4-Lite bus bundle for axil_regfile_ctrl: write address/data/response
// and read address/data channels with master and slave views.
interface axil_regfile_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axil_regfile_ctrl.sv
// AXI4-Lite slave in front of a NUM_REGS-word register file: independent AW/W
// acceptance, byte strobes, SLVERR decode, per-register write pulses, concurrent reads.
module axil_regfile_ctrl #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           aresetn,
    axil_regfile_ctrl_if.slave             s_axil,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFFS_W = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

    // write channel state
    wstate_e               wstate_q, wstate_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    // read channel state
    rstate_e               rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // commit bundle: which word, which data, which lanes
    logic                  commit_c;
    logic [IDX_W-1:0]      c_idx_c;
    logic [DATA_WIDTH-1:0] c_data_c;
    logic [STRB_W-1:0]     c_strb_c;
    logic                  c_in_range_c;

    logic                  aw_hs_c, w_hs_c, ar_hs_c;
    logic [IDX_W-1:0]      aw_idx_in_c, ar_idx_c;
    logic                  ar_in_range_c;
    logic [DATA_WIDTH-1:0] rd_word_c;
    logic                  unused_addr_bits;

    assign aw_hs_c     = s_axil.awvalid & awready_q;
    assign w_hs_c      = s_axil.wvalid & wready_q;
    assign ar_hs_c     = s_axil.arvalid & arready_q;
    assign aw_idx_in_c = s_axil.awaddr[ADDR_WIDTH-1:OFFS_W];
    assign ar_idx_c    = s_axil.araddr[ADDR_WIDTH-1:OFFS_W];

    // byte-offset bits never select anything
    assign unused_addr_bits = ^{s_axil.awaddr[OFFS_W-1:0], s_axil.araddr[OFFS_W-1:0]};

    // write FSM: next state, latches, commit selection and response
    always_comb begin
        wstate_d = wstate_q;
        aw_idx_d = aw_idx_q;
        w_data_d = w_data_q;
        w_strb_d = w_strb_q;
        bresp_d  = bresp_q;
        commit_c = 1'b0;
        c_idx_c  = aw_idx_q;
        c_data_c = w_data_q;
        c_strb_c = w_strb_q;

        case (wstate_q)
            W_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    commit_c = 1'b1;
                    c_idx_c  = aw_idx_in_c;
                    c_data_c = s_axil.wdata;
                    c_strb_c = s_axil.wstrb;
                    wstate_d = W_RESP;
                end else if (aw_hs_c) begin
                    aw_idx_d = aw_idx_in_c;
                    wstate_d = W_HAVE_ADDR;
                end else if (w_hs_c) begin
                    w_data_d = s_axil.wdata;
                    w_strb_d = s_axil.wstrb;
                    wstate_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs_c) begin
                    commit_c = 1'b1;
                    c_data_c = s_axil.wdata;
                    c_strb_c = s_axil.wstrb;
                    wstate_d = W_RESP;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs_c) begin
                    commit_c = 1'b1;
                    c_idx_c  = aw_idx_in_c;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axil.bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase

        c_in_range_c = (32'(c_idx_c) < NUM_REGS);
        if (commit_c) begin
            bresp_d = c_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end

        awready_d = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_DATA);
        wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_HAVE_ADDR);
        bvalid_d  = (wstate_d == W_RESP);
    end

    // register file next value and write pulses; unselected lanes hold
    always_comb begin
        wr_pulse_d = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_d[i] = regs_q[i];
            if (commit_c && c_in_range_c && (c_idx_c == IDX_W'(i))) begin
                for (int k = 0; k < int'(STRB_W); k++) begin
                    if (c_strb_c[k]) begin
                        regs_d[i][k*8 +: 8] = c_data_c[k*8 +: 8];
                    end
                end
                wr_pulse_d[i] = |c_strb_c;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wstate_q   <= W_IDLE;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wstate_q   <= wstate_d;
            aw_idx_q   <= aw_idx_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // read word mux over the pre-edge register contents
    always_comb begin
        rd_word_c = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (ar_idx_c == IDX_W'(i)) begin
                rd_word_c = regs_q[i];
            end
        end
    end

    assign ar_in_range_c = (32'(ar_idx_c) < NUM_REGS);

    // read FSM: next state and registered data/response
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        case (rstate_q)
            R_IDLE: begin
                if (ar_hs_c) begin
                    rstate_d = R_DATA;
                    rdata_d  = ar_in_range_c ? rd_word_c : '0;
                    rresp_d  = ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (s_axil.rready) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase

        arready_d = (rstate_d == R_IDLE);
        rvalid_d  = (rstate_d == R_DATA);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
        end
    end

    assign wr_pulse       = wr_pulse_q;
    assign s_axil.awready = awready_q;
    assign s_axil.wready  = wready_q;
    assign s_axil.bvalid  = bvalid_q;
    assign s_axil.bresp   = bresp_q;
    assign s_axil.arready = arready_q;
    assign s_axil.rvalid  = rvalid_q;
    assign s_axil.rdata   = rdata_q;
    assign s_axil.rresp   = rresp_q;
endmodule

// File: tb/tb_axil_regfile_ctrl.sv
// Directed self-checking bench for axil_regfile_ctrl (ADDR 8, DATA 32, 16 regs).
module tb_axil_regfile_ctrl;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    logic [NR*DW-1:0] regs_out;
    logic [NR-1:0]    wr_pulse;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axil_regfile_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axil_regfile_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk      (clk),
        .aresetn  (aresetn),
        .s_axil   (bus),
        .regs_out (regs_out),
        .wr_pulse (wr_pulse)
    );

    function automatic logic [DW-1:0] reg_at(input int i);
        return regs_out[i*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output logic [NR-1:0] pulse);
        bit aw_done, w_done, aw_f, w_f;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_f = bus.awvalid && bus.awready;
            w_f  = bus.wvalid && bus.wready;
            tick(); n++;
            if (aw_f) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_f)  begin w_done = 1;  bus.wvalid  = 1'b0; end
        end
        n = 0;
        while (!bus.bvalid && n < 20) begin tick(); n++; end
        checks++;
        if (bus.bvalid !== 1'b1) begin
            failures++;
            $display("FAIL write_handshake addr=%h got bvalid=%b want 1", addr, bus.bvalid);
        end
        resp = bus.bresp;
        pulse = wr_pulse;
        tick();
        bus.bready = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output logic [1:0] resp);
        int n;
        bit done;
        n = 0; done = 0;
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        while (!done && n < 20) begin
            done = bus.arready;
            tick(); n++;
        end
        bus.arvalid = 1'b0;
        n = 0;
        while (!bus.rvalid && n < 20) begin tick(); n++; end
        checks++;
        if (bus.rvalid !== 1'b1) begin
            failures++;
            $display("FAIL read_handshake addr=%h got rvalid=%b want 1", addr, bus.rvalid);
        end
        data = bus.rdata;
        resp = bus.rresp;
        tick();
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0 ||
            bus.bresp !== 2'b00 || bus.rresp !== 2'b00 || bus.rdata !== '0 ||
            regs_out !== '0 || wr_pulse !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b%b%b bv=%b rv=%b pulse=%h want all 0",
                     bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, wr_pulse);
        end
        aresetn = 1'b1;
        #1;
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
            failures++;
            $display("FAIL ready_before_edge got %b%b%b want 000",
                     bus.awready, bus.wready, bus.arready);
        end
        tick();
        checks++;
        if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            failures++;
            $display("FAIL ready_after_edge got %b%b%b want 111",
                     bus.awready, bus.wready, bus.arready);
        end
    endtask

    task automatic test_aw_w_same();
        bus.awaddr = 8'h04; bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || reg_at(1) !== 32'hDEADBEEF ||
            wr_pulse !== 16'h0002 || bus.awready !== 1'b0 || bus.wready !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_commit got bv=%b br=%b reg1=%h pulse=%h want 1 00 deadbeef 0002",
                     bus.bvalid, bus.bresp, reg_at(1), wr_pulse);
        end
        tick();
        checks++;
        if (bus.bvalid !== 1'b1 || wr_pulse !== 16'h0000) begin
            failures++;
            $display("FAIL pulse_one_cycle got bv=%b pulse=%h want 1 0000", bus.bvalid, wr_pulse);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
            failures++;
            $display("FAIL resp_release got bv=%b aw=%b w=%b want 0 1 1",
                     bus.bvalid, bus.awready, bus.wready);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] resp;
        logic [NR-1:0] pulse;
        do_write(8'h08, 32'hFFFFFFFF, 4'hF, resp, pulse);
        bus.wdata = 32'h11223344; bus.wstrb = 4'h5; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        tick();
        checks++;
        if (bus.wready !== 1'b0 || bus.awready !== 1'b1 || bus.bvalid !== 1'b0 ||
            reg_at(2) !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL have_data_wait got w=%b aw=%b bv=%b reg2=%h want 0 1 0 ffffffff",
                     bus.wready, bus.awready, bus.bvalid, reg_at(2));
        end
        bus.awaddr = 8'h08; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00 || reg_at(2) !== 32'hFF22FF44 ||
            wr_pulse !== 16'h0004) begin
            failures++;
            $display("FAIL strobe_merge got bv=%b br=%b reg2=%h pulse=%h want 1 00 ff22ff44 0004",
                     bus.bvalid, bus.bresp, reg_at(2), wr_pulse);
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp;
        logic [NR-1:0] pulse;
        logic [DW-1:0] data;
        logic [NR*DW-1:0] expv;
        expv = '0;
        expv[1*DW +: DW] = 32'hDEADBEEF;
        expv[2*DW +: DW] = 32'hFF22FF44;
        do_write(8'h40, 32'h12345678, 4'hF, resp, pulse);
        checks++;
        if (resp !== 2'b10 || pulse !== '0 || regs_out !== expv) begin
            failures++;
            $display("FAIL oor_write got bresp=%b pulse=%h regs_changed=%b want 10 0000 0",
                     resp, pulse, regs_out !== expv);
        end
        do_read(8'h40, data, resp);
        checks++;
        if (data !== 32'h0 || resp !== 2'b10) begin
            failures++;
            $display("FAIL oor_read got rdata=%h rresp=%b want 00000000 10", data, resp);
        end
        do_read(8'h07, data, resp);
        checks++;
        if (data !== 32'hDEADBEEF || resp !== 2'b00) begin
            failures++;
            $display("FAIL read_offset_ignored got rdata=%h rresp=%b want deadbeef 00", data, resp);
        end
    endtask

    task automatic test_strb_zero();
        logic [1:0] resp;
        logic [NR-1:0] pulse;
        do_write(8'h04, 32'h00000000, 4'h0, resp, pulse);
        checks++;
        if (resp !== 2'b00 || pulse !== '0 || reg_at(1) !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL zero_strobe got bresp=%b pulse=%h reg1=%h want 00 0000 deadbeef",
                     resp, pulse, reg_at(1));
        end
    endtask

    task automatic test_backpressure();
        bit bad;
        bus.awaddr = 8'h14; bus.wdata = 32'h0BADF00D; bus.wstrb = 4'hF; bus.araddr = 8'h08;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bad = (bus.bvalid !== 1'b1) || (bus.bresp !== 2'b00) || (bus.rvalid !== 1'b1) ||
                  (bus.rdata !== 32'hFF22FF44) || (bus.rresp !== 2'b00) ||
                  ({bus.awready, bus.wready, bus.arready} !== 3'b000) ||
                  (wr_pulse !== ((i == 0) ? 16'h0020 : 16'h0000)) ||
                  (reg_at(5) !== 32'h0BADF00D);
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL backpressure_hold cyc=%0d got bv=%b rv=%b rdata=%h rdy=%b%b%b pulse=%h reg5=%h",
                         i, bus.bvalid, bus.rvalid, bus.rdata, bus.awready, bus.wready,
                         bus.arready, wr_pulse, reg_at(5));
            end
            if (i < 4) tick();
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b0 || bus.rvalid !== 1'b0 ||
            {bus.awready, bus.wready, bus.arready} !== 3'b111) begin
            failures++;
            $display("FAIL backpressure_release got bv=%b rv=%b rdy=%b%b%b want 0 0 111",
                     bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready);
        end
    endtask

    task automatic test_same_edge();
        bus.awaddr = 8'h0C; bus.wdata = 32'hA5A5A5A5; bus.wstrb = 4'hF; bus.araddr = 8'h0C;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
        bus.bready = 1'b0; bus.rready = 1'b0;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0 || reg_at(3) !== 32'hA5A5A5A5 ||
            wr_pulse !== 16'h0008) begin
            failures++;
            $display("FAIL same_edge got rv=%b rdata=%h reg3=%h pulse=%h want 1 00000000 a5a5a5a5 0008",
                     bus.rvalid, bus.rdata, reg_at(3), wr_pulse);
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.bready = 1'b1; bus.rready = 1'b1;
        bus.awaddr = 8'h3C; bus.wdata = 32'h600D0001; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        tick();
        bus.wdata = 32'h600D0002;
        checks++;
        if (bus.bvalid !== 1'b1 || reg_at(15) !== 32'h600D0001 || wr_pulse !== 16'h8000) begin
            failures++;
            $display("FAIL b2b_first got bv=%b reg15=%h pulse=%h want 1 600d0001 8000",
                     bus.bvalid, reg_at(15), wr_pulse);
        end
        tick();
        checks++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1 || bus.wready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_gap got bv=%b aw=%b w=%b want 0 1 1",
                     bus.bvalid, bus.awready, bus.wready);
        end
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1 || reg_at(15) !== 32'h600D0002 || wr_pulse !== 16'h8000) begin
            failures++;
            $display("FAIL b2b_second got bv=%b reg15=%h pulse=%h want 1 600d0002 8000",
                     bus.bvalid, reg_at(15), wr_pulse);
        end
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] data;
        logic [1:0] resp;
        bit saw_b;
        bus.awaddr = 8'h04; bus.awvalid = 1'b1; bus.bready = 1'b0;
        tick();
        bus.awvalid = 1'b0;
        checks++;
        if (bus.awready !== 1'b0 || bus.wready !== 1'b1 || bus.bvalid !== 1'b0) begin
            failures++;
            $display("FAIL have_addr_state got aw=%b w=%b bv=%b want 0 1 0",
                     bus.awready, bus.wready, bus.bvalid);
        end
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (regs_out !== '0 || {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0 ||
            wr_pulse !== '0 || bus.rdata !== '0) begin
            failures++;
            $display("FAIL async_reset got rdy=%b%b%b bv=%b rv=%b regs_zero=%b want 000 0 0 1",
                     bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, regs_out === '0);
        end
        tick();
        aresetn = 1'b1;
        saw_b = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.bvalid !== 1'b0) saw_b = 1;
        end
        bus.wdata = 32'h00000077; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        if (bus.bvalid !== 1'b0) saw_b = 1;
        checks++;
        if (saw_b) begin
            failures++;
            $display("FAIL stale_response got bvalid=1 after reset want 0");
        end
        bus.awaddr = 8'h10; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b1 || reg_at(4) !== 32'h77 || reg_at(1) !== 32'h0) begin
            failures++;
            $display("FAIL post_reset_write got bv=%b reg4=%h reg1=%h want 1 00000077 00000000",
                     bus.bvalid, reg_at(4), reg_at(1));
        end
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        do_read(8'h04, data, resp);
        checks++;
        if (data !== 32'h0 || resp !== 2'b00) begin
            failures++;
            $display("FAIL read_after_reset got rdata=%h rresp=%b want 00000000 00", data, resp);
        end
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;
        test_reset();
        test_aw_w_same();
        test_w_before_aw();
        test_out_of_range();
        test_strb_zero();
        test_backpressure();
        test_same_edge();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end
endmodule
